// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage and the iterative multiply/divide unit.
// The master issues operations and consumes results; the slave is the unit itself.
interface muldiv_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [XLEN-1:0]  req_a;
    logic [XLEN-1:0]  req_b;
    logic [TAG_W-1:0] req_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [XLEN-1:0]  rsp_result;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_tag
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_tag
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on magnitudes,
// one bit per cycle, with sign fix-up at the end and single-cycle divide-by-zero/overflow paths.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    muldiv_if.slave   bus,
    output logic      busy
);
    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(XLEN);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q;
    logic [TAG_W-1:0]   tag_q;
    logic [XLEN-1:0]    opb_q;
    logic               neg_q;
    logic               fast_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*XLEN-1:0]  acc_q;
    logic [XLEN-1:0]    rsp_result_q;
    logic [TAG_W-1:0]   rsp_tag_q;

    logic               accept;
    logic               a_signed, b_signed, a_neg, b_neg, is_div;
    logic               div_zero, div_ovf, fast_in, neg_in;
    logic [XLEN-1:0]    abs_a, abs_b, fast_val;
    logic [XLEN:0]      mul_sum, rem_sh, diff;
    logic [2*XLEN-1:0]  mul_next, div_next, prod_fix;
    logic [XLEN-1:0]    quo_fix, rem_fix, final_result;

    assign bus.req_ready  = (state_q == IDLE) && !flush;
    assign bus.rsp_valid  = (state_q == DONE);
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_tag    = rsp_tag_q;
    assign busy           = (state_q != IDLE);
    assign accept         = bus.req_valid && bus.req_ready;

    // Operand decode at accept: magnitudes, result sign and the RISC-V defined special cases.
    always_comb begin
        is_div   = bus.req_op[2];
        a_signed = (bus.req_op == OP_MULH) || (bus.req_op == OP_MULHSU) ||
                   (bus.req_op == OP_DIV)  || (bus.req_op == OP_REM);
        b_signed = (bus.req_op == OP_MULH) || (bus.req_op == OP_DIV) || (bus.req_op == OP_REM);
        a_neg    = a_signed && bus.req_a[XLEN-1];
        b_neg    = b_signed && bus.req_b[XLEN-1];
        abs_a    = a_neg ? (-bus.req_a) : bus.req_a;
        abs_b    = b_neg ? (-bus.req_b) : bus.req_b;
        neg_in   = a_neg ^ (b_neg && !(is_div && bus.req_op[1]));
        div_zero = is_div && (bus.req_b == '0);
        div_ovf  = ((bus.req_op == OP_DIV) || (bus.req_op == OP_REM)) &&
                   (bus.req_a == MIN_NEG) && (bus.req_b == '1);
        fast_in  = div_zero || div_ovf;
        fast_val = '0;
        if (div_zero)
            fast_val = bus.req_op[1] ? bus.req_a : '1;
        else if (div_ovf)
            fast_val = bus.req_op[1] ? '0 : bus.req_a;
    end

    // One iteration of each algorithm; acc holds {hi, lo} = {product hi, multiplier} or {remainder, quotient}.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        diff     = rem_sh - {1'b0, opb_q};
        if (!diff[XLEN])
            div_next = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else
            div_next = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end

    always_comb begin
        prod_fix = neg_q ? (-acc_q) : acc_q;
        quo_fix  = neg_q ? (-acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
        rem_fix  = neg_q ? (-acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                       final_result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              final_result = quo_fix;
            default:                      final_result = rem_fix;
        endcase
        if (fast_q)
            final_result = acc_q[XLEN-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = CALC;
            CALC: if (cnt_q == CNT_MAX) state_d = DONE;
            DONE: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush)
            state_d = IDLE;
    end

    // Fast paths preload the counter at its limit so they finish on the very next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q         <= '0;
            tag_q        <= '0;
            opb_q        <= '0;
            neg_q        <= 1'b0;
            fast_q       <= 1'b0;
            cnt_q        <= '0;
            acc_q        <= '0;
            rsp_result_q <= '0;
            rsp_tag_q    <= '0;
        end else if (!flush) begin
            if (accept) begin
                op_q   <= bus.req_op;
                tag_q  <= bus.req_tag;
                opb_q  <= abs_b;
                neg_q  <= neg_in;
                fast_q <= fast_in;
                cnt_q  <= fast_in ? CNT_MAX : '0;
                acc_q  <= {{XLEN{1'b0}}, (fast_in ? fast_val : abs_a)};
            end else if (state_q == CALC) begin
                if (cnt_q != CNT_MAX) begin
                    acc_q <= op_q[2] ? div_next : mul_next;
                    cnt_q <= cnt_q + CNT_W'(1);
                end else begin
                    rsp_result_q <= final_result;
                    rsp_tag_q    <= tag_q;
                end
            end
        end
    end
endmodule
